regfile_wb_arbiter: RTL and testbench

//  Write-side driver for the CPU register file. Merges two result sources into the single

---
 rtl/regfile_pkg.sv | 15 +
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file writeback types for the arbiter and its result FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  // One pending regfile write: destination index plus result value.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t with per-entry destination match for the pending scoreboard.
// Latency: pushed entry visible at head the cycle after push; no write-through bypass.
// Backpressure: full/empty flags; push while full and pop while empty are ignored.
// Ports: clk/rst, push/push_entry, pop/head, full/empty, query_a/query_b -> hit_a/hit_b per slot.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  input  logic [ADDR_WIDTH-1:0] query_a,
  input  logic [ADDR_WIDTH-1:0] query_b,
  output logic [DEPTH-1:0]      hit_a,
  output logic [DEPTH-1:0]      hit_b
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] slot_vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      slot_vld <= '0;
    end else begin
      if (do_push) begin
        wr_ptr           <= wr_ptr + 1'b1;
        slot_vld[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr           <= rd_ptr + 1'b1;
        slot_vld[rd_ptr] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: slot_vld gates every use of stale contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_a[i] = slot_vld[i] && (mem[i].rd == query_a);
      hit_b[i] = slot_vld[i] && (mem[i].rd == query_b);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges the ALU result stream and the buffered memory/MULDIV stream into one regfile write port.
// Latency: 1 cycle, winner registered into wb_* on posedge; queued memory results wait >=1 cycle.
// Backpressure: ALU has none (alu_stall is a one-cycle hold request); memory uses valid/ready.
// Ports: clk, rst (async, active-high); alu_valid/rd/data, alu_stall; mem_valid/ready/rd/data;
//        wb_we/rd/data; query_rs/rt -> rs/rt_pending. Optional macro WB_STATS_EN adds
//        stat_stall_cnt and stat_full_cnt saturating counters.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH   = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = regfile_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_stall,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] query_rs,
  input  logic [ADDR_WIDTH-1:0] query_rt,
  output logic                  rs_pending,
  output logic                  rt_pending
`ifdef WB_STATS_EN
  ,
  output logic [15:0]           stat_stall_cnt,
  output logic [15:0]           stat_full_cnt
`endif
);

  import regfile_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  wb_entry_t             push_entry;
  wb_entry_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  mem_xfer;
  logic                  alu_win;
  logic                  starve_hit;
  logic [SW-1:0]         starve_cnt;
  logic [FIFO_DEPTH-1:0] hit_rs;
  logic [FIFO_DEPTH-1:0] hit_rt;

  // No bypass: readiness depends only on occupancy, never on a same-cycle pop.
  assign mem_ready  = !rst && !fifo_full;
  assign mem_xfer   = mem_valid && mem_ready;
  // rd==0 results complete the handshake but are never queued.
  assign fifo_push  = mem_xfer && (mem_rd != '0);
  assign push_entry = '{rd: mem_rd, data: mem_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .query_a    (query_rs),
    .query_b    (query_rt),
    .hit_a      (hit_rs),
    .hit_b      (hit_rt)
  );

  // A stall cycle belongs to the FIFO head; any ALU result offered then is dropped.
  // An ALU result with rd==0 still occupies the port for that cycle.
  always_comb begin
    alu_win  = 1'b0;
    fifo_pop = 1'b0;
    if (alu_stall) begin
      fifo_pop = !fifo_empty;
    end else if (alu_valid) begin
      alu_win = 1'b1;
    end else begin
      fifo_pop = !fifo_empty;
    end
  end

  assign starve_hit = alu_win && !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      alu_stall  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      wb_we     <= alu_win ? (alu_rd != '0) : fifo_pop;
      alu_stall <= starve_hit;
      if (alu_win && (alu_rd != '0)) begin
        wb_rd   <= alu_rd;
        wb_data <= alu_data;
      end else if (fifo_pop) begin
        wb_rd   <= head.rd;
        wb_data <= head.data;
      end
      if (fifo_pop) begin
        starve_cnt <= '0;
      end else if (alu_win && !fifo_empty) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // A register is pending while queued or while sitting in the write stage.
  assign rs_pending = (query_rs != '0) && ((|hit_rs) || (wb_we && (wb_rd == query_rs)));
  assign rt_pending = (query_rt != '0) && ((|hit_rt) || (wb_we && (wb_rd == query_rt)));

`ifdef WB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cnt <= '0;
      stat_full_cnt  <= '0;
    end else begin
      if (alu_stall && (stat_stall_cnt != 16'hFFFF)) begin
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
      end
      if (mem_valid && !mem_ready && (stat_full_cnt != 16'hFFFF)) begin
        stat_full_cnt <= stat_full_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reference model predicts each regfile write.
// Latency: checks wb_* one cycle after each stimulus vector.
// Backpressure: model tracks FIFO occupancy to predict mem_ready and alu_stall.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int SL    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  query_rs;
  logic [4:0]  query_rt;
  logic        rs_pending;
  logic        rt_pending;
`ifdef WB_STATS_EN
  logic [15:0] stat_stall_cnt;
  logic [15:0] stat_full_cnt;
`endif

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .query_rs   (query_rs),
    .query_rt   (query_rt),
    .rs_pending (rs_pending),
    .rt_pending (rt_pending)
`ifdef WB_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_full_cnt  (stat_full_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit        we;
    bit [4:0]  rd;
    bit [31:0] data;
  } exp_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  exp_t     sb[$];
  ent_t     mq[$];
  int       scnt;
  bit       mstall;
  bit       last_we;
  bit [4:0] last_rd;

  function automatic bit m_pend(input bit [4:0] q);
    if (q == 0) return 1'b0;
    if (last_we && last_rd == q) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    mq.delete();
    sb.delete();
    scnt    = 0;
    mstall  = 1'b0;
    last_we = 1'b0;
    last_rd = '0;
  endtask

  // One stimulus vector: drive, check combinational outputs, predict, clock, check write port.
  task automatic cyc(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                     input bit mv, input bit [4:0] mrd, input bit [31:0] md,
                     input bit [4:0] qs, input bit [4:0] qt);
    exp_t e;
    ent_t h;
    bit   xfer;
    bit   nstall;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    query_rs  = qs;
    query_rt  = qt;
    #1;
    chk("mem_ready", mem_ready, mq.size() < DEPTH);
    chk("alu_stall", alu_stall, mstall);
    chk("rs_pending", rs_pending, m_pend(qs));
    chk("rt_pending", rt_pending, m_pend(qt));
    xfer   = mv && (mq.size() < DEPTH);
    nstall = 1'b0;
    e.we   = 1'b0;
    e.rd   = '0;
    e.data = '0;
    if (mstall) begin
      if (mq.size() > 0) begin
        h = mq.pop_front();
        e.we = 1'b1; e.rd = h.rd; e.data = h.data;
        scnt = 0;
      end
    end else if (av) begin
      e.we = (ard != 0); e.rd = ard; e.data = ad;
      if (mq.size() > 0) begin
        if (scnt == SL - 1) nstall = 1'b1;
        scnt++;
      end
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      e.we = 1'b1; e.rd = h.rd; e.data = h.data;
      scnt = 0;
    end
    if (xfer && mrd != 0) mq.push_back('{rd: mrd, data: md});
    mstall = nstall;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("wb_we", wb_we, e.we);
    if (e.we) begin
      chk("wb_rd", wb_rd, e.rd);
      chk("wb_data", wb_data, e.data);
    end
    last_we = e.we;
    last_rd = e.rd;
  endtask

  task automatic idle(input bit [4:0] qs, input bit [4:0] qt);
    cyc(0, 0, 0, 0, 0, 0, qs, qt);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 1; mem_rd = 3; mem_data = 0;
    query_rs = 0; query_rt = 0;
    model_clear();
    #12;
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_alu_stall", alu_stall, 0);
    chk("rst_mem_ready", mem_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ALU only, then its destination shows pending while in the write stage.
    cyc(1, 5, 32'hDEAD, 0, 0, 0, 0, 0);
    idle(5, 6);

    // rd==0 from both sources: handshake completes, nothing written or queued.
    cyc(1, 0, 32'h1, 1, 0, 32'h2, 0, 0);
    idle(0, 0);

    // Fill the FIFO behind a busy ALU; the fifth offer sees mem_ready low.
    for (int i = 0; i < 4; i++)
      cyc(1, 5'(10 + i), 32'hA0 + i, 1, 5'(1 + i), 32'hB0 + i, 5'(i), 5'(i + 1));
    cyc(1, 20, 32'hC0, 1, 9, 32'hC9, 3, 4);

    // Keep the ALU busy until starvation forces the head out (ALU offer during stall is dropped).
    for (int i = 0; i < 6; i++)
      cyc(1, 5'(21 + i), 32'hD0 + i, 0, 0, 0, 1, 2);

    // Three queued: simultaneous push and pop keeps occupancy and order.
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, 1, 5'(12 + i), 32'hE0 + i, 5'(12 + i), 2);

    // Reset mid-operation with entries queued.
    rst = 1'b1;
    #1;
    chk("midrst_wb_we", wb_we, 0);
    chk("midrst_mem_ready", mem_ready, 0);
    @(posedge clk);
    #1;
    chk("midrst_hold_wb_we", wb_we, 0);
    rst = 1'b0;
    model_clear();
    idle(13, 14);
    idle(15, 3);

    // Randomised traffic over a small register range to exercise pending and ordering.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
          1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    for (int i = 0; i < 8; i++)
      idle(5'(i), 5'(7 - i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
